// File: rtl/combo_lock_param.sv
// Parametrised keypad combination lock.
// Ten one-hot key lines enter BCD digits into a shifting entry register; a
// user-programmable code gates the unlock output. Failed entries are counted
// and lead to a timed lockout; an idle unlocked lock relocks on its own.
module combo_lock_param #(
    parameter int DIGITS         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 5000
) (
    input  logic                             clk,
    input  logic                             hard_rst_n,
    input  logic [9:0]                       keypad,
    input  logic                             enter,
    input  logic                             clr,
    input  logic                             prog,
    output logic                             unlock,
    output logic                             incorrect,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic [4*DIGITS-1:0]              try_monitor,
    output logic [1:0]                       state_monitor
);

    localparam int CW   = 4 * DIGITS;
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int DW   = $clog2(DIGITS + 1);
    localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_PROG     = 2'b10,
        ST_LOCKOUT  = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   pw_reg, pw_next;
    logic [CW-1:0]   try_reg, try_next;
    logic [DW-1:0]   digit_count_reg, digit_count_next;
    logic [FW-1:0]   fail_count_reg, fail_count_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            unlock_reg, incorrect_reg, incorrect_next, locked_out_reg;

    // Input sample history for edge detection
    logic [9:0]      key_cur_reg, key_prev_reg;
    logic            enter_cur_reg, enter_prev_reg;
    logic            clr_cur_reg, clr_prev_reg;
    logic            prog_cur_reg, prog_prev_reg;

    logic            press_evt, enter_rise, clr_rise, prog_rise;
    logic            enter_evt, prog_evt, press_act;
    logic [3:0]      key_bcd;
    logic [3:0]      key_terms [10];
    logic [CW-1:0]   try_shift;
    logic [DW-1:0]   digit_inc;
    logic [FW-1:0]   fail_inc;
    logic [TW-1:0]   timer_inc;
    logic            entry_full;

    // A press is a single key appearing after an all-released sample, so held
    // keys and chords never register as digits.
    assign press_evt  = $onehot(key_cur_reg) && (key_prev_reg == 10'd0);
    assign enter_rise = enter_cur_reg & ~enter_prev_reg;
    assign clr_rise   = clr_cur_reg & ~clr_prev_reg;
    assign prog_rise  = prog_cur_reg & ~prog_prev_reg;

    // Same-cycle priority: clr beats enter beats prog beats a digit press
    assign enter_evt  = enter_rise & ~clr_rise;
    assign prog_evt   = prog_rise & ~clr_rise & ~enter_rise;
    assign press_act  = press_evt & ~clr_rise & ~enter_rise & ~prog_rise;

    // One-hot to BCD: each key line contributes its own index
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_key_term
            assign key_terms[gi] = key_cur_reg[gi] ? 4'(gi) : 4'd0;
        end
    endgenerate

    // OR-reduce the per-key terms into the pressed digit
    always_comb begin
        key_bcd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            key_bcd = key_bcd | key_terms[i];
        end
    end

    // New digit enters at the bottom; the oldest digit falls off the top
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign try_shift = key_bcd;
        end else begin : g_shift_many
            assign try_shift = {try_reg[CW-5:0], key_bcd};
        end
    endgenerate

    assign entry_full = (digit_count_reg == DW'(DIGITS));
    assign digit_inc  = entry_full ? digit_count_reg : digit_count_reg + 1'b1;
    assign fail_inc   = fail_count_reg + 1'b1;
    assign timer_inc  = (timer_reg == TW'(TMAX)) ? timer_reg : timer_reg + 1'b1;

    // Next-state and datapath update for the lock FSM
    always_comb begin
        state_next       = state_reg;
        pw_next          = pw_reg;
        try_next         = try_reg;
        digit_count_next = digit_count_reg;
        fail_count_next  = fail_count_reg;
        timer_next       = '0;
        incorrect_next   = 1'b0;
        case (state_reg)
            ST_LOCKED: begin
                if (clr_rise) begin
                    try_next         = '0;
                    digit_count_next = '0;
                end else if (enter_evt) begin
                    if (entry_full && (try_reg == pw_reg)) begin
                        state_next      = ST_UNLOCKED;
                        fail_count_next = '0;
                    end else begin
                        incorrect_next   = 1'b1;
                        try_next         = '0;
                        digit_count_next = '0;
                        fail_count_next  = fail_inc;
                        if (fail_inc == FW'(MAX_TRIES)) begin
                            state_next = ST_LOCKOUT;
                        end
                    end
                end else if (press_act) begin
                    try_next         = try_shift;
                    digit_count_next = digit_inc;
                end
            end
            ST_UNLOCKED: begin
                // Any user activity restarts the idle timer
                if (clr_rise) begin
                    timer_next = '0;
                end else if (enter_evt) begin
                    state_next       = ST_LOCKED;
                    try_next         = '0;
                    digit_count_next = '0;
                end else if (prog_evt) begin
                    state_next       = ST_PROG;
                    try_next         = '0;
                    digit_count_next = '0;
                end else if (press_evt) begin
                    timer_next = '0;
                end else if ((RELOCK_CYCLES != 0) && (timer_reg == TW'(RELOCK_CYCLES - 1))) begin
                    state_next       = ST_LOCKED;
                    try_next         = '0;
                    digit_count_next = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end
            ST_PROG: begin
                // The old code remains in force until a full entry is committed
                if (clr_rise) begin
                    try_next         = '0;
                    digit_count_next = '0;
                end else if (enter_evt) begin
                    if (entry_full) begin
                        pw_next          = try_reg;
                        state_next       = ST_LOCKED;
                        try_next         = '0;
                        digit_count_next = '0;
                    end
                end else if (press_act) begin
                    try_next         = try_shift;
                    digit_count_next = digit_inc;
                end
            end
            ST_LOCKOUT: begin
                if (timer_reg == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_next       = ST_LOCKED;
                    fail_count_next  = '0;
                    try_next         = '0;
                    digit_count_next = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end
            default: begin
                state_next = ST_LOCKED;
            end
        endcase
    end

    // State, datapath, input history and registered outputs
    always_ff @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            state_reg       <= ST_LOCKED;
            pw_reg          <= '0;
            try_reg         <= '0;
            digit_count_reg <= '0;
            fail_count_reg  <= '0;
            timer_reg       <= '0;
            key_cur_reg     <= '0;
            key_prev_reg    <= '0;
            enter_cur_reg   <= 1'b0;
            enter_prev_reg  <= 1'b0;
            clr_cur_reg     <= 1'b0;
            clr_prev_reg    <= 1'b0;
            prog_cur_reg    <= 1'b0;
            prog_prev_reg   <= 1'b0;
            unlock_reg      <= 1'b0;
            incorrect_reg   <= 1'b0;
            locked_out_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pw_reg          <= pw_next;
            try_reg         <= try_next;
            digit_count_reg <= digit_count_next;
            fail_count_reg  <= fail_count_next;
            timer_reg       <= timer_next;
            key_cur_reg     <= keypad;
            key_prev_reg    <= key_cur_reg;
            enter_cur_reg   <= enter;
            enter_prev_reg  <= enter_cur_reg;
            clr_cur_reg     <= clr;
            clr_prev_reg    <= clr_cur_reg;
            prog_cur_reg    <= prog;
            prog_prev_reg   <= prog_cur_reg;
            unlock_reg      <= (state_next == ST_UNLOCKED) || (state_next == ST_PROG);
            incorrect_reg   <= incorrect_next;
            locked_out_reg  <= (state_next == ST_LOCKOUT);
        end
    end

    assign unlock        = unlock_reg;
    assign incorrect     = incorrect_reg;
    assign locked_out    = locked_out_reg;
    assign fail_count    = fail_count_reg;
    assign digit_count   = digit_count_reg;
    assign try_monitor   = try_reg;
    assign state_monitor = state_reg;

endmodule
